cnn1d_class_vote: RTL and testbench
===================================

// Module: cnn1d_class_vote
// PURPOSE
//  Parametrised classifier head for the 1D-CNN; successor to the fixed two-neuron
//  compare at the top level. Takes NUM_CLASSES neuron-layer outputs and does a serial
//  signed argmax with top-2 margin. Applies a confidence gate, then a sliding majority
//  vote over the last VOTE_DEPTH confident decisions to give a debounced class.
// PARAMETERS
//  DATA_WIDTH      32      signed fixed-point width of neuron outputs
//  NUM_CLASSES     2       number of neuron outputs (>=2)
//  VOTE_DEPTH      5       decision history length (>=1)
//  VOTE_THRESHOLD  3       votes needed to change smoothed class (1..VOTE_DEPTH)
//  MARGIN_MIN      0       signed min (best - second) for a confident decision
//  DEFAULT_CLASS   0       smoothed class after reset/clear ("NEW")
//  CLASS_WIDTH     $clog2(NUM_CLASSES)  localparam, index width
// PORTS
//  clk             in   1                         clock
//  rst             in   1                         synchronous, active-high reset
//  cls_ready_in    out  1                         block can accept a vector
//  cls_valid_in    in   1                         input vector valid
//  cls_data_in     in   DATA_WIDTH x NUM_CLASSES  unpacked [0:NUM_CLASSES-1], signed
//  cls_clear       in   1                         clear vote history (1-cycle pulse)
//  cls_ready_out   in   1                         downstream ready
//  cls_valid_out   out  1                         result valid
//  cls_raw_out     out  CLASS_WIDTH               argmax of this vector
//  cls_margin_out  out  DATA_WIDTH                best - second, saturating, >=0
//  cls_confident   out  1                         margin >= MARGIN_MIN
//  cls_class_out   out  CLASS_WIDTH               smoothed (voted) class
//  cls_condition   out  1                         cls_class_out != DEFAULT_CLASS
// BEHAVIOUR
//  - FSM IDLE -> SCAN -> VOTE -> OUT -> IDLE. cls_ready_in=1 only in IDLE.
//  - IDLE: on valid&&ready, register the vector. best=data[0], best_idx=0,
//    second=most-negative, idx=1. Go to SCAN.
//  - SCAN: one compare per cycle, idx=1..NUM_CLASSES-1, all signed.
//    data[idx] > best (strict) -> second<=best, best<=data[idx], best_idx<=idx.
//    Else data[idx] > second -> second<=data[idx].
//    Ties keep the lower index. After idx=NUM_CLASSES-1, go to VOTE.
//  - VOTE (1 cycle): margin = best - second, computed at DATA_WIDTH+1, saturated to
//    max positive. confident = margin >= MARGIN_MIN (signed).
//    If confident: push best_idx into a history shift reg with a per-slot valid bit;
//    oldest drops once full. If not confident: history unchanged.
//    Per class, count valid slots equal to it (post-push). If exactly one class has
//    count >= VOTE_THRESHOLD, smoothed <= it; else hold. Tie at threshold -> hold.
//  - OUT: cls_valid_out=1, all result outputs stable until cls_ready_out. Then IDLE.
//  - Latency: acceptance edge to first cls_valid_out high = NUM_CLASSES+1 cycles.
//    Throughput: one vector per NUM_CLASSES+2 cycles with ready_out held high.
//  - cls_clear: clears all slot valid bits and sets smoothed to DEFAULT_CLASS.
//    In any state except VOTE: applied that cycle.
//    Coincident with a VOTE push: clear first, then the push becomes the sole entry.
//    An in-flight vector is unaffected.
//  - Reset (any state, incl. mid-SCAN/OUT): state=IDLE, cls_valid_out=0,
//    history empty, cls_raw_out=0, cls_margin_out=0, cls_confident=0,
//    cls_class_out=DEFAULT_CLASS, cls_condition=0. Partial vectors are discarded.
//  - cls_data_in is sampled only at acceptance; input changes afterwards are ignored.
// TESTING (DATA_WIDTH=32, FRACTION=16, NUM_CLASSES=4, DEPTH=5, THRESH=3, MARGIN_MIN=0x2000)
//  1 in {1.0,3.0,-2.0,2.5} (0x10000,0x30000,0xFFFE0000,0x28000) -> raw=1,
//    margin=0x8000, confident=1, valid_out 5 cycles after accept.
//  2 Tie in {2.0,2.0,0,0} -> raw=0, margin=0, confident=0, history unchanged,
//    class_out unchanged.
//  3 Five confident vectors with argmax 2,2,1,2,0 -> class_out goes to 2 on the 4th
//    result, stays 2 on the 5th. condition=1 from the 4th result.
//  4 Extremes {0x7FFFFFFF,0x80000000,..} -> margin saturates to 0x7FFFFFFF,
//    raw=0, no wrap.
//  5 ready_out low for 10 cycles in OUT -> valid_out and all outputs held,
//    ready_in=0. A second vector is accepted only after the handshake.
//  6 rst mid-SCAN, then cls_clear pulse coincident with a VOTE push -> reset values
//    immediately. After clear, history holds exactly 1 entry; class_out=DEFAULT_CLASS.

Source files
------------

// File: rtl/cnn1d_class_vote.sv
`default_nettype none
// ============================================================================
//  Module   : cnn1d_class_vote
//  Brief    : 1D-CNN classifier head. Serial signed argmax with top-2 margin,
//             confidence gate and sliding majority vote over recent decisions.
//  Revision : 1.0 - initial release
// ============================================================================
module cnn1d_class_vote #(
    parameter int                            DATA_WIDTH     = 32,
    parameter int                            NUM_CLASSES    = 2,
    parameter int                            VOTE_DEPTH     = 5,
    parameter int                            VOTE_THRESHOLD = 3,
    parameter logic signed [DATA_WIDTH-1:0]  MARGIN_MIN     = '0,
    parameter int                            DEFAULT_CLASS  = 0,
    localparam int                           CLASS_WIDTH    = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          cls_ready_in,
    input  logic                          cls_valid_in,
    input  logic signed [DATA_WIDTH-1:0]  cls_data_in [0:NUM_CLASSES-1],
    input  logic                          cls_clear,
    input  logic                          cls_ready_out,
    output logic                          cls_valid_out,
    output logic [CLASS_WIDTH-1:0]        cls_raw_out,
    output logic [DATA_WIDTH-1:0]         cls_margin_out,
    output logic                          cls_confident,
    output logic [CLASS_WIDTH-1:0]        cls_class_out,
    output logic                          cls_condition
);

    localparam int                       CNT_W         = $clog2(VOTE_DEPTH + 1);
    localparam logic [CLASS_WIDTH-1:0]   c_default_cls = CLASS_WIDTH'(DEFAULT_CLASS);
    localparam logic [CLASS_WIDTH-1:0]   c_last_idx    = CLASS_WIDTH'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0]         c_threshold   = CNT_W'(VOTE_THRESHOLD);
    localparam logic [DATA_WIDTH-1:0]    c_most_neg    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]    c_most_pos    = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_VOTE = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic signed [DATA_WIDTH-1:0]   data_q [0:NUM_CLASSES-1];
    logic signed [DATA_WIDTH-1:0]   data_d [0:NUM_CLASSES-1];
    logic signed [DATA_WIDTH-1:0]   best_q, best_d;
    logic signed [DATA_WIDTH-1:0]   second_q, second_d;
    logic [CLASS_WIDTH-1:0]         best_idx_q, best_idx_d;
    logic [CLASS_WIDTH-1:0]         idx_q, idx_d;
    logic [CLASS_WIDTH-1:0]         hist_q [0:VOTE_DEPTH-1];
    logic [CLASS_WIDTH-1:0]         hist_d [0:VOTE_DEPTH-1];
    logic [VOTE_DEPTH-1:0]          hist_vld_q, hist_vld_d;
    logic [CLASS_WIDTH-1:0]         raw_q, raw_d;
    logic [DATA_WIDTH-1:0]          margin_q, margin_d;
    logic                           conf_q, conf_d;
    logic [CLASS_WIDTH-1:0]         smoothed_q, smoothed_d;
    logic                           condition_q, condition_d;

    logic signed [DATA_WIDTH-1:0]   scan_val;
    logic signed [DATA_WIDTH:0]     margin_wide;
    logic [DATA_WIDTH-1:0]          margin_sat;
    logic                           confident;
    logic [VOTE_DEPTH-1:0]          vld_base;
    logic [CNT_W-1:0]               vote_cnt;
    logic                           win_found;
    logic                           win_multi;
    logic [CLASS_WIDTH-1:0]         win_cls;

    // best >= second always, so the widened difference is non-negative
    assign margin_wide = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};
    assign margin_sat  = (margin_wide[DATA_WIDTH:DATA_WIDTH-1] != 2'b00) ? c_most_pos
                                                                        : margin_wide[DATA_WIDTH-1:0];
    assign confident   = ($signed(margin_sat) >= MARGIN_MIN);
    assign scan_val    = data_q[idx_q];

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        best_d      = best_q;
        second_d    = second_q;
        best_idx_d  = best_idx_q;
        idx_d       = idx_q;
        hist_d      = hist_q;
        hist_vld_d  = hist_vld_q;
        raw_d       = raw_q;
        margin_d    = margin_q;
        conf_d      = conf_q;
        smoothed_d  = smoothed_q;
        vld_base    = hist_vld_q;
        vote_cnt    = '0;
        win_found   = 1'b0;
        win_multi   = 1'b0;
        win_cls     = '0;

        case (state_q)
            ST_IDLE: begin
                if (cls_valid_in) begin
                    data_d     = cls_data_in;
                    best_d     = cls_data_in[0];
                    best_idx_d = '0;
                    second_d   = c_most_neg;
                    idx_d      = CLASS_WIDTH'(1);
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_val > best_q) begin
                    second_d   = best_q;
                    best_d     = scan_val;
                    best_idx_d = idx_q;
                end else if (scan_val > second_q) begin
                    second_d   = scan_val;
                end
                if (idx_q == c_last_idx) begin
                    state_d = ST_VOTE;
                end else begin
                    idx_d = idx_q + CLASS_WIDTH'(1);
                end
            end
            ST_VOTE: begin
                raw_d    = best_idx_q;
                margin_d = margin_sat;
                conf_d   = confident;
                // A coincident clear empties history before this decision is pushed
                if (cls_clear) begin
                    vld_base   = '0;
                    hist_vld_d = '0;
                    smoothed_d = c_default_cls;
                end
                if (confident) begin
                    for (int s = VOTE_DEPTH - 1; s > 0; s--) begin
                        hist_d[s]     = hist_q[s-1];
                        hist_vld_d[s] = vld_base[s-1];
                    end
                    hist_d[0]     = best_idx_q;
                    hist_vld_d[0] = 1'b1;
                end
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    vote_cnt = '0;
                    for (int s = 0; s < VOTE_DEPTH; s++) begin
                        if (hist_vld_d[s] && (hist_d[s] == CLASS_WIDTH'(c))) begin
                            vote_cnt = vote_cnt + CNT_W'(1);
                        end
                    end
                    if (vote_cnt >= c_threshold) begin
                        if (win_found) begin
                            win_multi = 1'b1;
                        end
                        win_found = 1'b1;
                        win_cls   = CLASS_WIDTH'(c);
                    end
                end
                if (win_found && !win_multi) begin
                    smoothed_d = win_cls;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (cls_ready_out) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cls_clear && (state_q != ST_VOTE)) begin
            hist_vld_d = '0;
            smoothed_d = c_default_cls;
        end

        condition_d = (smoothed_d != c_default_cls);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hist_vld_q  <= '0;
            raw_q       <= '0;
            margin_q    <= '0;
            conf_q      <= 1'b0;
            smoothed_q  <= c_default_cls;
            condition_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_vld_q  <= hist_vld_d;
            raw_q       <= raw_d;
            margin_q    <= margin_d;
            conf_q      <= conf_d;
            smoothed_q  <= smoothed_d;
            condition_q <= condition_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q     <= data_d;
        best_q     <= best_d;
        second_q   <= second_d;
        best_idx_q <= best_idx_d;
        idx_q      <= idx_d;
        hist_q     <= hist_d;
    end

    assign cls_ready_in   = (state_q == ST_IDLE);
    assign cls_valid_out  = (state_q == ST_OUT);
    assign cls_raw_out    = raw_q;
    assign cls_margin_out = margin_q;
    assign cls_confident  = conf_q;
    assign cls_class_out  = smoothed_q;
    assign cls_condition  = condition_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn1d_class_vote.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnn1d_class_vote
//  Brief    : Directed self-checking bench for cnn1d_class_vote (4 classes,
//             depth 5, threshold 3, margin minimum 0x2000).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnn1d_class_vote;

    localparam int NC = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cls_ready_in;
    logic               cls_valid_in;
    logic signed [31:0] cls_data_in [0:NC-1];
    logic               cls_clear;
    logic               cls_ready_out;
    logic               cls_valid_out;
    logic [1:0]         cls_raw_out;
    logic [31:0]        cls_margin_out;
    logic               cls_confident;
    logic [1:0]         cls_class_out;
    logic               cls_condition;

    int vectors     = 0;
    int miscompares = 0;
    int lat;

    cnn1d_class_vote #(
        .DATA_WIDTH     (32),
        .NUM_CLASSES    (NC),
        .VOTE_DEPTH     (5),
        .VOTE_THRESHOLD (3),
        .MARGIN_MIN     (32'sh0000_2000),
        .DEFAULT_CLASS  (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cls_ready_in   (cls_ready_in),
        .cls_valid_in   (cls_valid_in),
        .cls_data_in    (cls_data_in),
        .cls_clear      (cls_clear),
        .cls_ready_out  (cls_ready_out),
        .cls_valid_out  (cls_valid_out),
        .cls_raw_out    (cls_raw_out),
        .cls_margin_out (cls_margin_out),
        .cls_confident  (cls_confident),
        .cls_class_out  (cls_class_out),
        .cls_condition  (cls_condition)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        cls_data_in[0] = a;
        cls_data_in[1] = b;
        cls_data_in[2] = c;
        cls_data_in[3] = d;
    endtask

    // lat counts clock edges from the accepting edge (inclusive) to valid_out
    task automatic wait_result(input bit clr_in_vote, output int l);
        l = 1;
        while (!cls_valid_out && l < 30) begin
            if (clr_in_vote && l == 4) cls_clear = 1'b1;
            tick();
            cls_clear = 1'b0;
            l++;
        end
        check("valid_out", 32'(cls_valid_out), 32'd1);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input bit clr_in_vote, output int l);
        int guard = 0;
        while (!cls_ready_in && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_in", 32'(cls_ready_in), 32'd1);
        load(a, b, c, d);
        cls_valid_in = 1'b1;
        tick();
        cls_valid_in = 1'b0;
        load(32'h0, 32'h0, 32'h0, 32'h0);
        wait_result(clr_in_vote, l);
    endtask

    initial begin
        rst           = 1'b1;
        cls_valid_in  = 1'b0;
        cls_clear     = 1'b0;
        cls_ready_out = 1'b1;
        load(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) tick();
        rst = 1'b0;

        check("rst_ready_in",  32'(cls_ready_in),  32'd1);
        check("rst_valid_out", 32'(cls_valid_out), 32'd0);
        check("rst_class",     32'(cls_class_out), 32'd0);
        check("rst_condition", 32'(cls_condition), 32'd0);

        // Basic argmax: {1.0, 3.0, -2.0, 2.5}
        send(32'h0001_0000, 32'h0003_0000, 32'hFFFE_0000, 32'h0002_8000, 1'b0, lat);
        check("t1_latency", 32'(lat),            32'd5);
        check("t1_raw",     32'(cls_raw_out),    32'd1);
        check("t1_margin",  cls_margin_out,      32'h0000_8000);
        check("t1_conf",    32'(cls_confident),  32'd1);
        check("t1_class",   32'(cls_class_out),  32'd0);
        tick();
        check("t1_release", 32'(cls_valid_out),  32'd0);

        // Tie keeps lower index, zero margin is not confident
        send(32'h0002_0000, 32'h0002_0000, 32'h0, 32'h0, 1'b0, lat);
        check("t2_raw",    32'(cls_raw_out),   32'd0);
        check("t2_margin", cls_margin_out,     32'h0);
        check("t2_conf",   32'(cls_confident), 32'd0);
        check("t2_class",  32'(cls_class_out), 32'd0);
        tick();

        cls_clear = 1'b1;
        tick();
        cls_clear = 1'b0;
        check("clr_idle_class", 32'(cls_class_out), 32'd0);

        // Vote sequence 2,2,1,2,0
        send(32'h0, 32'h0, 32'h0004_0000, 32'h0, 1'b0, lat);
        check("t3_r1_raw",   32'(cls_raw_out),   32'd2);
        check("t3_r1_class", 32'(cls_class_out), 32'd0);
        tick();
        send(32'h0, 32'h0, 32'h0004_0000, 32'h0, 1'b0, lat);
        check("t3_r2_class", 32'(cls_class_out), 32'd0);
        tick();
        send(32'h0, 32'h0004_0000, 32'h0, 32'h0, 1'b0, lat);
        check("t3_r3_raw",   32'(cls_raw_out),   32'd1);
        check("t3_r3_class", 32'(cls_class_out), 32'd0);
        tick();
        send(32'h0, 32'h0, 32'h0004_0000, 32'h0, 1'b0, lat);
        check("t3_r4_class", 32'(cls_class_out), 32'd2);
        check("t3_r4_cond",  32'(cls_condition), 32'd1);
        tick();
        send(32'h0004_0000, 32'h0, 32'h0, 32'h0, 1'b0, lat);
        check("t3_r5_raw",   32'(cls_raw_out),   32'd0);
        check("t3_r5_class", 32'(cls_class_out), 32'd2);
        check("t3_r5_cond",  32'(cls_condition), 32'd1);
        tick();

        // Extremes: margin saturates; history 0,0,2,1,2 ties at 2 votes -> hold
        send(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        check("t4_raw",    32'(cls_raw_out),   32'd0);
        check("t4_margin", cls_margin_out,     32'h7FFF_FFFF);
        check("t4_conf",   32'(cls_confident), 32'd1);
        check("t4_class",  32'(cls_class_out), 32'd2);
        tick();

        // Backpressure: outputs held, a pending vector waits for the handshake
        cls_ready_out = 1'b0;
        send(32'h0, 32'h0, 32'h0, 32'h0004_0000, 1'b0, lat);
        load(32'h0, 32'h0, 32'h0004_0000, 32'h0);
        cls_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold_valid",  32'(cls_valid_out), 32'd1);
            check("t5_hold_ready",  32'(cls_ready_in),  32'd0);
            check("t5_hold_raw",    32'(cls_raw_out),   32'd3);
            check("t5_hold_margin", cls_margin_out,     32'h0004_0000);
        end
        check("t5_hold_class", 32'(cls_class_out), 32'd2);
        cls_ready_out = 1'b1;
        tick();
        check("t5_release_ready", 32'(cls_ready_in), 32'd1);
        tick();
        cls_valid_in = 1'b0;
        load(32'h0, 32'h0, 32'h0, 32'h0);
        wait_result(1'b0, lat);
        check("t5_second_lat",   32'(lat),           32'd5);
        check("t5_second_raw",   32'(cls_raw_out),   32'd2);
        check("t5_second_class", 32'(cls_class_out), 32'd2);
        check("t5_second_cond",  32'(cls_condition), 32'd1);
        tick();

        // Reset mid-SCAN
        load(32'h0, 32'h0004_0000, 32'h0, 32'h0);
        cls_valid_in = 1'b1;
        tick();
        cls_valid_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid",  32'(cls_valid_out),  32'd0);
        check("t6_rst_ready",  32'(cls_ready_in),   32'd1);
        check("t6_rst_raw",    32'(cls_raw_out),    32'd0);
        check("t6_rst_margin", cls_margin_out,      32'h0);
        check("t6_rst_conf",   32'(cls_confident),  32'd0);
        check("t6_rst_class",  32'(cls_class_out),  32'd0);
        check("t6_rst_cond",   32'(cls_condition),  32'd0);
        repeat (6) begin
            tick();
            check("t6_rst_no_out", 32'(cls_valid_out), 32'd0);
        end

        // Two class-1 pushes, third coincident with clear -> sole entry
        send(32'h0, 32'h0004_0000, 32'h0, 32'h0, 1'b0, lat);
        tick();
        send(32'h0, 32'h0004_0000, 32'h0, 32'h0, 1'b0, lat);
        check("t6_pre_class", 32'(cls_class_out), 32'd0);
        tick();
        send(32'h0, 32'h0004_0000, 32'h0, 32'h0, 1'b1, lat);
        check("t6_clr_raw",   32'(cls_raw_out),   32'd1);
        check("t6_clr_class", 32'(cls_class_out), 32'd0);
        check("t6_clr_cond",  32'(cls_condition), 32'd0);
        tick();
        send(32'h0, 32'h0004_0000, 32'h0, 32'h0, 1'b0, lat);
        check("t6_post1_class", 32'(cls_class_out), 32'd0);
        tick();
        send(32'h0, 32'h0004_0000, 32'h0, 32'h0, 1'b0, lat);
        check("t6_post2_class", 32'(cls_class_out), 32'd1);
        check("t6_post2_cond",  32'(cls_condition), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
